mem_sched: RTL and testbench

Single-port memory scheduler and execution sequencer for the `riscv_cpu` core. Shares one memory bus between instruction fetch and data load/store, and holds the fetched instruction in an internal IR. Pulses a commit enable so the core's PC and register file advance exactly once per retired instruction. Sits between the core and the memory/bus model.

---
 rtl/mem_sched.sv | 193 +++++++++++++++++++
 tb/tb_mem_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_sched.sv
// ---------------------------------------------------------------------------
// mem_sched
//   Single-port memory scheduler and execution sequencer for riscv_cpu.
//   Shares one memory bus between instruction fetch and data load/store,
//   holds the fetched instruction in the IR, and pulses cpu_en once per
//   retired instruction so the core's PC and register file advance in step.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   pc         in   current PC from core
//   ld_req     in   decoded IR is a load (sampled in EXEC)
//   st_req     in   decoded IR is a store (sampled in EXEC)
//   memop      in   funct3 size/sign code
//   mem_addr   in   data address
//   st_data    in   store data, LSB-aligned
//   inst       out  IR contents (nop after reset)
//   ld_data    out  aligned, extended load data
//   cpu_en     out  one-cycle commit pulse
//   misalign   out  sticky misaligned-access flag (core halted)
//   instret    out  retired-instruction counter
//   m_valid    out  memory request valid
//   m_ready    in   memory accepts request
//   m_addr     out  word address
//   m_wen      out  request is a write
//   m_wmask    out  byte-lane write enables
//   m_wdata    out  lane-shifted write data
//   m_rvalid   in   response valid
//   m_rdata    in   read data
// ---------------------------------------------------------------------------
module mem_sched #(
   parameter int unsigned RESET_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        ld_req,
   input  logic        st_req,
   input  logic [2:0]  memop,
   input  logic [31:0] mem_addr,
   input  logic [31:0] st_data,
   output logic [31:0] inst,
   output logic [31:0] ld_data,
   output logic        cpu_en,
   output logic        misalign,
   output logic [63:0] instret,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   output logic        m_wen,
   output logic [3:0]  m_wmask,
   output logic [31:0] m_wdata,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_F_REQ  = 3'd1;
   localparam logic [2:0] S_F_WAIT = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_D_REQ  = 3'd4;
   localparam logic [2:0] S_D_WAIT = 3'd5;
   localparam logic [2:0] S_WB     = 3'd6;
   localparam logic [2:0] S_HALT   = 3'd7;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [3:0]  W_LAST  = 4'(RESET_WAIT - 1);

   // Byte-lane write mask for a store of the given size at byte offset off.
   function automatic logic [3:0] fn_st_mask(input logic [2:0] op, input logic [1:0] off);
      logic [3:0] mask;
      case (op[1:0])
         2'b00:   mask = 4'b0001 << off;
         2'b01:   mask = 4'b0011 << off;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Shift the addressed bytes down to bit 0, then zero/sign-extend.
   // memop[2] set selects the unsigned variants (bu/hu).
   function automatic logic [31:0] fn_ld_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  op);
      logic [31:0] shifted;
      logic [31:0] res;
      shifted = rdata >> {off, 3'b000};
      case (op[1:0])
         2'b00:   res = {{24{~op[2] & shifted[7]}},  shifted[7:0]};
         2'b01:   res = {{16{~op[2] & shifted[15]}}, shifted[15:0]};
         default: res = shifted;
      endcase
      return res;
   endfunction

   logic [2:0]  r_state;
   logic [3:0]  r_wait;
   logic [31:0] r_ir;
   logic [31:0] r_ld_data;
   logic        r_misalign;
   logic [63:0] r_instret;
   logic [31:0] r_d_addr;
   logic        r_d_wen;
   logic [3:0]  r_d_wmask;
   logic [31:0] r_d_wdata;
   logic [1:0]  r_d_off;
   logic [2:0]  r_d_memop;

   logic [2:0]  w_next;
   logic        w_is_mem;
   logic        w_misal;
   logic        w_cpu_en;
   logic        w_unused;

   // PC is word-aligned on the bus; its low bits never reach the memory.
   assign w_unused = &{1'b0, pc[1:0]};

   assign w_is_mem = ld_req | st_req;
   // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes never misalign.
   assign w_misal  = ((memop[1:0] == 2'b01) && mem_addr[0]) ||
                     (memop[1] && (mem_addr[1:0] != 2'b00));
   assign w_cpu_en = ((r_state == S_EXEC) && !w_is_mem) || (r_state == S_WB);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (r_wait == W_LAST) w_next = S_F_REQ;
         S_F_REQ:  if (m_ready)  w_next = S_F_WAIT;
         S_F_WAIT: if (m_rvalid) w_next = S_EXEC;
         S_EXEC: begin
            if (w_is_mem) w_next = w_misal ? S_HALT : S_D_REQ;
            else          w_next = S_F_REQ;
         end
         S_D_REQ:  if (m_ready)  w_next = S_D_WAIT;
         S_D_WAIT: if (m_rvalid) w_next = S_WB;
         S_WB:     w_next = S_F_REQ;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_wait     <= 4'd0;
         r_ir       <= NOP;
         r_ld_data  <= 32'd0;
         r_misalign <= 1'b0;
         r_instret  <= 64'd0;
         r_d_addr   <= 32'd0;
         r_d_wen    <= 1'b0;
         r_d_wmask  <= 4'd0;
         r_d_wdata  <= 32'd0;
         r_d_off    <= 2'd0;
         r_d_memop  <= 3'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) r_wait <= r_wait + 4'd1;
         if ((r_state == S_F_WAIT) && m_rvalid) r_ir <= m_rdata;
         // Capture the data-phase request in EXEC so the bus fields are
         // register-driven and cannot move while a request is stalled.
         // Store wins when both requests are raised.
         if (r_state == S_EXEC) begin
            r_d_addr  <= {mem_addr[31:2], 2'b00};
            r_d_wen   <= st_req;
            r_d_wmask <= st_req ? fn_st_mask(memop, mem_addr[1:0]) : 4'd0;
            r_d_wdata <= st_req ? (st_data << {mem_addr[1:0], 3'b000}) : 32'd0;
            r_d_off   <= mem_addr[1:0];
            r_d_memop <= memop;
            if (w_is_mem && w_misal) r_misalign <= 1'b1;
         end
         if ((r_state == S_D_WAIT) && m_rvalid && !r_d_wen)
            r_ld_data <= fn_ld_extend(m_rdata, r_d_off, r_d_memop);
         if (w_cpu_en) r_instret <= r_instret + 64'd1;
      end
   end

   assign inst     = r_ir;
   assign ld_data  = r_ld_data;
   assign cpu_en   = w_cpu_en;
   assign misalign = r_misalign;
   assign instret  = r_instret;

   // Bus outputs depend only on state and registers (plus the core's PC,
   // which cannot change in F_REQ since no commit happens there).
   assign m_valid = (r_state == S_F_REQ) || (r_state == S_D_REQ);
   assign m_addr  = (r_state == S_F_REQ) ? {pc[31:2], 2'b00} :
                    (r_state == S_D_REQ) ? r_d_addr : 32'd0;
   assign m_wen   = (r_state == S_D_REQ) && r_d_wen;
   assign m_wmask = (r_state == S_D_REQ) ? r_d_wmask : 4'd0;
   assign m_wdata = (r_state == S_D_REQ) ? r_d_wdata : 32'd0;

endmodule

// File: tb/tb_mem_sched.sv
// ---------------------------------------------------------------------------
// tb_mem_sched
//   Directed bench for mem_sched. The initial block plays both the core
//   (pc, ld_req/st_req, memop, addresses) and a zero-wait memory that
//   returns m_rvalid one cycle after each accepted request.
// ---------------------------------------------------------------------------
module tb_mem_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        ld_req;
   logic        st_req;
   logic [2:0]  memop;
   logic [31:0] mem_addr;
   logic [31:0] st_data;
   logic [31:0] inst;
   logic [31:0] ld_data;
   logic        cpu_en;
   logic        misalign;
   logic [63:0] instret;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_addr;
   logic        m_wen;
   logic [3:0]  m_wmask;
   logic [31:0] m_wdata;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   mem_sched #(.RESET_WAIT(2)) dut (
      .clk(clk), .rst(rst), .pc(pc), .ld_req(ld_req), .st_req(st_req),
      .memop(memop), .mem_addr(mem_addr), .st_data(st_data), .inst(inst),
      .ld_data(ld_data), .cpu_en(cpu_en), .misalign(misalign),
      .instret(instret), .m_valid(m_valid), .m_ready(m_ready),
      .m_addr(m_addr), .m_wen(m_wen), .m_wmask(m_wmask), .m_wdata(m_wdata),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: handshake sampled at the negedge, rvalid driven 1ns after
   // the posedge that accepted the request.
   task automatic tick();
      logic hs;
      @(negedge clk);
      hs = m_valid && m_ready;
      @(posedge clk);
      #1;
      m_rvalid = hs;
   endtask

   // From F_REQ: fetch one instruction and land in EXEC.
   task automatic do_fetch(input logic [31:0] word);
      m_rdata = word;
      tick();
      tick();
      check("fetch_inst", 64'(inst), 64'(word));
   endtask

   // From EXEC: run one load/store, optionally stalling m_ready in D_REQ.
   task automatic mem_op(input string tag, input logic ld, input logic st,
                         input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdat,
                         input logic [3:0] emask, input logic [31:0] ewdata,
                         input logic [31:0] eld, input logic [63:0] eret,
                         input int stall);
      int nobs;
      ld_req = ld; st_req = st; memop = op; mem_addr = addr;
      st_data = sdata; m_rdata = rdat;
      m_ready = (stall == 0);
      #1;
      check({tag, "_exec_cpu_en"}, 64'(cpu_en), 64'd0);
      tick();
      nobs = (stall == 0) ? 1 : stall;
      for (int k = 0; k < nobs; k++) begin
         check({tag, "_m_valid"}, 64'(m_valid), 64'd1);
         check({tag, "_m_addr"},  64'(m_addr), 64'({addr[31:2], 2'b00}));
         check({tag, "_m_wen"},   64'(m_wen), 64'(st));
         check({tag, "_m_wmask"}, 64'(m_wmask), 64'(emask));
         check({tag, "_m_wdata"}, 64'(m_wdata), 64'(ewdata));
         if (stall != 0) check({tag, "_stall_cpu_en"}, 64'(cpu_en), 64'd0);
         if (k != nobs - 1) tick();
      end
      m_ready = 1'b1;
      tick();
      check({tag, "_dwait_cpu_en"}, 64'(cpu_en), 64'd0);
      tick();
      check({tag, "_wb_cpu_en"}, 64'(cpu_en), 64'd1);
      if (ld && !st) check({tag, "_ld_data"}, 64'(ld_data), 64'(eld));
      tick();
      check({tag, "_instret"}, instret, eret);
      check({tag, "_next_fetch"}, 64'(m_valid), 64'd1);
      ld_req = 1'b0; st_req = 1'b0;
   endtask

   initial begin
      logic [63:0] frozen;
      rst = 1'b0; pc = 32'h8000_0000; ld_req = 1'b0; st_req = 1'b0;
      memop = 3'd0; mem_addr = 32'd0; st_data = 32'd0;
      m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0000_0013;

      repeat (2) @(posedge clk);
      #1;
      check("rst_inst",     64'(inst), 64'h13);
      check("rst_ld_data",  64'(ld_data), 64'd0);
      check("rst_cpu_en",   64'(cpu_en), 64'd0);
      check("rst_misalign", 64'(misalign), 64'd0);
      check("rst_instret",  instret, 64'd0);
      check("rst_bus",      64'({m_valid, m_wen, m_wmask, m_addr, m_wdata}), 64'd0);

      // Release: two IDLE cycles, then the first fetch.
      rst = 1'b1;
      tick();
      check("idle_m_valid", 64'(m_valid), 64'd0);
      tick();
      check("freq_m_valid", 64'(m_valid), 64'd1);
      check("freq_m_addr",  64'(m_addr), 64'h8000_0000);
      check("freq_wen_mask", 64'({m_wen, m_wmask}), 64'd0);

      // Back-to-back ALU instructions: commit every third cycle.
      for (int i = 0; i < 12; i++) begin
         tick();
         check("alu_cpu_en", 64'(cpu_en), 64'((i % 3) == 1));
      end
      check("alu_instret", instret, 64'd4);

      do_fetch(32'h0030_0083);
      mem_op("lb",  1, 0, 3'b000, 32'h8000_1003, 32'd0, 32'h80FF_7F01,
             4'b0000, 32'd0, 32'hFFFF_FF80, 64'd5, 0);
      do_fetch(32'h0030_4083);
      mem_op("lbu", 1, 0, 3'b100, 32'h8000_1003, 32'd0, 32'h80FF_7F01,
             4'b0000, 32'd0, 32'h0000_0080, 64'd6, 0);
      do_fetch(32'h0010_9123);
      mem_op("sh",  0, 1, 3'b001, 32'h8000_1002, 32'h0000_BEEF, 32'd0,
             4'b1100, 32'hBEEF_0000, 32'd0, 64'd7, 0);
      do_fetch(32'h0010_80A3);
      mem_op("sb_stall", 0, 1, 3'b000, 32'h8000_1001, 32'h0000_00A5, 32'd0,
             4'b0010, 32'h0000_A500, 32'd0, 64'd8, 5);
      do_fetch(32'h0010_A223);
      mem_op("both_sw", 1, 1, 3'b010, 32'h8000_1004, 32'h1234_5678, 32'hDEAD_BEEF,
             4'b1111, 32'h1234_5678, 32'd0, 64'd9, 0);
      check("ld_data_kept", 64'(ld_data), 64'h0000_0080);

      // Misaligned lw: halt with no data request.
      do_fetch(32'h0020_2083);
      ld_req = 1'b1; memop = 3'b010; mem_addr = 32'h8000_1002;
      tick();
      check("mis_flag",    64'(misalign), 64'd1);
      check("mis_m_valid", 64'(m_valid), 64'd0);
      frozen = instret;
      check("mis_instret", frozen, 64'd9);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("halt_bus",     64'({m_valid, cpu_en}), 64'd0);
         check("halt_instret", instret, 64'd9);
      end
      rst = 1'b0;
      #1;
      check("mis_cleared", 64'(misalign), 64'd0);
      check("mis_instret_rst", instret, 64'd0);
      tick();
      rst = 1'b1; ld_req = 1'b0;
      tick();
      tick();
      check("refetch_valid", 64'(m_valid), 64'd1);

      // Reset in F_WAIT; a late response after release is dropped.
      m_rdata = 32'h1234_5678;
      tick();
      rst = 1'b0; m_rvalid = 1'b0;
      #1;
      check("fw_rst_inst",  64'(inst), 64'h13);
      check("fw_rst_valid", 64'(m_valid), 64'd0);
      tick();
      rst = 1'b1; m_rvalid = 1'b1;
      tick();
      check("late_rvalid_inst", 64'(inst), 64'h13);
      check("late_idle_valid",  64'(m_valid), 64'd0);
      tick();
      check("fresh_fetch_valid", 64'(m_valid), 64'd1);
      check("fresh_fetch_addr",  64'(m_addr), 64'h8000_0000);
      check("fresh_fetch_inst",  64'(inst), 64'h13);
      do_fetch(32'h0050_0093);
      #1;
      check("fresh_cpu_en", 64'(cpu_en), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
